// File: rtl/inst_queue_decode.sv
// Instruction queue with pre-decode: a circular buffer of fetched {inst, pc}
// entries that presents up to ISSUE_W decoded instructions per cycle straight
// from the head of the queue. The second issue slot is gated by pairing rules:
// no privileged instruction in either slot, no two HI/LO-unit operations
// together, and nothing paired behind a reserved-instruction head.
module inst_queue_decode #(
  parameter int DEPTH   = 8,  // power of two, >= 4
  parameter int FETCH_W = 2,  // 1 or 2
  parameter int ISSUE_W = 2   // 1 or 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_cnt,
  input  logic [32*FETCH_W-1:0]        in_inst,
  input  logic [31:0]                  in_pc,
  output logic [ISSUE_W-1:0]           out_valid,
  output logic [32*ISSUE_W-1:0]        out_inst,
  output logic [32*ISSUE_W-1:0]        out_pc,
  output logic [3*ISSUE_W-1:0]         out_class,
  output logic [ISSUE_W-1:0]           out_ri,
  input  logic [1:0]                   issue_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_BRANCH = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_HILO   = 3'd4,
    CLS_PRIV   = 3'd5
  } inst_class_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;

  logic                 w_push;
  logic [CNT_W-1:0]     w_push_n;
  logic [CNT_W-1:0]     w_pop_n;

  entry_t               w_slot       [ISSUE_W];
  inst_class_e          w_slot_class [ISSUE_W];
  logic [ISSUE_W-1:0]   w_slot_ri;
  logic [ISSUE_W-1:0]   w_valid;

  // MIPS-I class decode from opcode / funct / rs fields.
  function automatic inst_class_e decode_class(input logic [31:0] inst);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    opcode       = inst[31:26];
    funct        = inst[5:0];
    rs           = inst[25:21];
    decode_class = CLS_ALU;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h08, 6'h09:                      decode_class = CLS_BRANCH; // JR, JALR
          6'h10, 6'h11, 6'h12, 6'h13,
          6'h18, 6'h19, 6'h1A, 6'h1B:        decode_class = CLS_HILO;
          6'h0C, 6'h0D:                      decode_class = CLS_PRIV;   // SYSCALL, BREAK
          default:                           decode_class = CLS_ALU;
        endcase
      end
      6'h01, 6'h02, 6'h03, 6'h04,
      6'h05, 6'h06, 6'h07:                   decode_class = CLS_BRANCH;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:     decode_class = CLS_LOAD;
      6'h28, 6'h29, 6'h2B:                   decode_class = CLS_STORE;
      6'h10: begin
        // COP0: MFC0 (rs=0), MTC0 (rs=4), ERET (CO=1, funct=0x18)
        if (rs == 5'h00 || rs == 5'h04 || (rs == 5'h10 && funct == 6'h18))
          decode_class = CLS_PRIV;
      end
      default:                               decode_class = CLS_ALU;
    endcase
  endfunction

  // REGIMM with an rt other than BLTZ/BGEZ/BLTZAL/BGEZAL is reserved.
  function automatic logic decode_ri(input logic [31:0] inst);
    logic [4:0] rt;
    rt        = inst[20:16];
    decode_ri = (inst[31:26] == 6'h01) &&
                !(rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11);
  endfunction

  // Space check uses registered occupancy only, so it never waits on issue.
  assign in_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_W);
  assign w_push   = in_valid & in_ready & ~flush;
  assign w_push_n = w_push ? CNT_W'(in_cnt) : '0;
  assign w_pop_n  = CNT_W'(issue_cnt);
  assign count    = r_count;

  // Pointer and occupancy state; flush overrides any push/pop in the same cycle.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(issue_cnt);
      r_count  <= r_count + w_push_n - w_pop_n;
    end
  end

  // Queue storage: write the valid prefix of the fetch group at wr_ptr.
  // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (2'(i) < in_cnt) begin
          r_mem[r_wr_ptr + PTR_W'(i)] <= '{inst: in_inst[32*i +: 32],
                                          pc:   in_pc + 32'(4 * i)};
        end
      end
    end
  end

  // Read the head entries and decode them.
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      w_slot[k]       = r_mem[r_rd_ptr + PTR_W'(k)];
      w_slot_class[k] = decode_class(w_slot[k].inst);
      w_slot_ri[k]    = decode_ri(w_slot[k].inst);
    end
  end

  assign w_valid[0] = (r_count != '0);

  generate
    if (ISSUE_W == 2) begin : g_pair
      // Second slot issues only when the pair is free of structural conflicts.
      assign w_valid[1] = (r_count >= CNT_W'(2)) &&
                          (w_slot_class[0] != CLS_PRIV) &&
                          (w_slot_class[1] != CLS_PRIV) &&
                          !((w_slot_class[0] == CLS_HILO) && (w_slot_class[1] == CLS_HILO)) &&
                          !w_slot_ri[0];
    end
  endgenerate

  // Drive outputs; inactive slots are forced to zero.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    out_valid = w_valid;
    out_inst  = '0;
    out_pc    = '0;
    out_class = '0;
    out_ri    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (w_valid[k]) begin
        out_inst[32*k +: 32] = w_slot[k].inst;
        out_pc[32*k +: 32]   = w_slot[k].pc;
        out_class[3*k +: 3]  = w_slot_class[k];
        out_ri[k]            = w_slot_ri[k];
      end
    end
  end

endmodule
